// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter letting NUM_REQ valid/ready producers share one FIFO write port.
// A write is issued only when the FIFO is sure to accept it; overflow and lost acks latch sticky errors.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_WIDTH = 16,
    parameter  int CNT_W      = 16,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic [ID_W-1:0]               grant_id,
    output logic [CNT_W-1:0]              wr_count,
    output logic                          ovf_err,
    output logic                          ack_err
);

    logic [NUM_REQ-1:0][FIFO_WIDTH-1:0] w_req_arr;
    logic [NUM_REQ-1:0]                 w_grant;
    logic [ID_W-1:0]                    w_gid;
    logic [ID_W-1:0]                    w_rr_nxt;
    logic                               w_space_ok;
    logic                               w_xfer;
    int                                 w_dist;
    int                                 w_best;

    // [0] = write issued this cycle, [1] = write whose ack is due this cycle
    logic [1:0]                         r_vld_pipe;
    logic [FIFO_WIDTH-1:0]              r_data;
    logic [ID_W-1:0]                    r_gid;
    logic [ID_W-1:0]                    r_rr_ptr;
    logic [CNT_W-1:0]                   r_count;
    logic                               r_ovf_err;
    logic                               r_ack_err;

    assign w_req_arr  = req_data;
    // A write already in flight at almostfull will fill the FIFO, so hold off.
    assign w_space_ok = !fifo_full && !(fifo_almostfull && r_vld_pipe[0]);

    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_dist  = 0;
        w_best  = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i >= int'(r_rr_ptr)) ? (i - int'(r_rr_ptr)) : (i + NUM_REQ - int'(r_rr_ptr));
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_gid  = ID_W'(i);
            end
        end
        if (rst_n && w_space_ok && (w_best < NUM_REQ))
            w_grant[w_gid] = 1'b1;
    end

    assign w_xfer   = |w_grant;
    assign w_rr_nxt = (w_gid == ID_W'(NUM_REQ - 1)) ? '0 : (w_gid + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_data     <= '0;
            r_gid      <= '0;
            r_rr_ptr   <= '0;
            r_count    <= '0;
            r_ovf_err  <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_xfer};
            if (w_xfer) begin
                r_data   <= w_req_arr[w_gid];
                r_gid    <= w_gid;
                r_rr_ptr <= w_rr_nxt;
                r_count  <= r_count + 1'b1;
            end
            if (r_vld_pipe[1] && !fifo_wr_ack)
                r_ack_err <= 1'b1;
            if (fifo_overflow)
                r_ovf_err <= 1'b1;
        end
    end

    assign req_ready    = w_grant;
    assign fifo_wr_en   = r_vld_pipe[0];
    assign fifo_data_in = r_data;
    assign grant_id     = r_gid;
    assign wr_count     = r_count;
    assign ovf_err      = r_ovf_err;
    assign ack_err      = r_ack_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a FIFO emulator drives the flags, a spec-level model predicts every output.
module tb_fifo_wr_arbiter;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int CW    = 16;
    localparam int IW    = 2;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full = 1'b0;
    logic           fifo_almostfull = 1'b0;
    logic           fifo_wr_ack = 1'b0;
    logic           fifo_overflow = 1'b0;
    logic [IW-1:0]  grant_id;
    logic [CW-1:0]  wr_count;
    logic           ovf_err;
    logic           ack_err;

    fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull), .fifo_wr_ack(fifo_wr_ack),
        .fifo_overflow(fifo_overflow), .grant_id(grant_id), .wr_count(wr_count),
        .ovf_err(ovf_err), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int           m_rr, m_gid;
    bit           m_wen, m_pend, m_ovf, m_ack;
    logic [W-1:0] m_data;
    logic [CW-1:0] m_cnt;

    // FIFO emulator and stimulus knobs
    int           f_cnt = 0;
    int           rd_pct = 0;
    int           valid_pct = 100;
    bit           rd_once = 0, inj_drop = 0, inj_ovf = 0;
    logic [N-1:0] en_mask = '0;

    // values seen at the last compare point
    logic [N-1:0]  obs_ready;
    logic          obs_wen, obs_ovf, obs_ack;
    logic [CW-1:0] obs_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0; m_gid = 0; m_wen = 0; m_pend = 0; m_ovf = 0; m_ack = 0;
        m_data = '0; m_cnt = '0;
    endtask

    // First valid requester at or after the pointer, if the FIFO certainly has room.
    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int j;
        r = '0;
        if (!rst_n || fifo_full || (fifo_almostfull && m_wen)) return r;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (req_valid[j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic cycle();
        logic [N-1:0]   er, nv;
        logic [N*W-1:0] nd;
        bit             rd, acc, n_ack, n_ovf, old_wen;
        @(negedge clk);
        if (!rst_n) model_reset();
        er = exp_ready();
        obs_ready = req_ready; obs_wen = fifo_wr_en; obs_cnt = wr_count;
        obs_ovf = ovf_err; obs_ack = ack_err;
        chk("req_ready",    64'(req_ready),    64'(er));
        chk("fifo_wr_en",   64'(fifo_wr_en),   64'(m_wen));
        chk("fifo_data_in", 64'(fifo_data_in), 64'(m_data));
        chk("grant_id",     64'(grant_id),     64'(m_gid));
        chk("wr_count",     64'(wr_count),     64'(m_cnt));
        chk("ovf_err",      64'(ovf_err),      64'(m_ovf));
        chk("ack_err",      64'(ack_err),      64'(m_ack));
        if (rst_n) begin
            old_wen = m_wen;
            if (m_pend && !fifo_wr_ack) m_ack = 1;
            if (fifo_overflow) m_ovf = 1;
            m_wen = 0;
            for (int i = 0; i < N; i++) begin
                if (er[i]) begin
                    m_wen = 1; m_data = req_data[i*W +: W]; m_gid = i;
                    m_rr = (i + 1) % N; m_cnt = m_cnt + 1'b1;
                end
            end
            m_pend = old_wen;
        end
        acc   = obs_wen && (f_cnt < DEPTH);
        n_ovf = (obs_wen && (f_cnt == DEPTH)) || inj_ovf;
        n_ack = acc && !inj_drop;
        rd    = (f_cnt > 0) && (rd_once || ($urandom_range(99) < rd_pct));
        f_cnt = f_cnt + int'(acc) - int'(rd);
        rd_once = 0;
        nv = req_valid; nd = req_data;
        for (int i = 0; i < N; i++) begin
            if (!en_mask[i]) nv[i] = 1'b0;
            else if (req_valid[i] && !obs_ready[i]) nv[i] = 1'b1;
            else if ($urandom_range(99) < valid_pct) begin
                nv[i] = 1'b1;
                nd[i*W +: W] = W'($urandom);
            end else nv[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        fifo_full = (f_cnt == DEPTH); fifo_almostfull = (f_cnt == DEPTH - 1);
        fifo_wr_ack = n_ack; fifo_overflow = n_ovf;
        req_valid = nv; req_data = nd;
    endtask

    task automatic do_reset(input logic [N-1:0] mask);
        rst_n = 1'b0; en_mask = mask; valid_pct = 100; f_cnt = 0;
        fifo_full = 0; fifo_almostfull = 0; fifo_wr_ack = 0; fifo_overflow = 0;
        cycle();
        chk("rst_ready", 64'(obs_ready), 64'(0));
        chk("rst_wen",   64'(obs_wen),   64'(0));
        chk("rst_cnt",   64'(obs_cnt),   64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        int grants;
        model_reset();
        #2;
        do_reset(4'hF);

        rd_pct = 0;
        cycle(); chk("rr0", 64'(obs_ready), 64'(4'b0001));
        cycle(); chk("rr1", 64'(obs_ready), 64'(4'b0010));
        cycle(); chk("rr2", 64'(obs_ready), 64'(4'b0100));
        cycle(); chk("rr3", 64'(obs_ready), 64'(4'b1000));
        cycle(); chk("rr_cnt", 64'(obs_cnt), 64'(4)); chk("rr_wrap", 64'(obs_ready), 64'(4'b0001));

        do_reset(4'hF);
        cycle(); chk("rst_first", 64'(obs_ready), 64'(4'b0001));

        do_reset(4'b1010);
        cycle(); chk("skip0", 64'(obs_ready), 64'(4'b0010));
        cycle(); chk("skip1", 64'(obs_ready), 64'(4'b1000));
        cycle(); chk("skip2", 64'(obs_ready), 64'(4'b0010));

        do_reset(4'hF);
        rd_pct = 0;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (c == 9)  chk("af_ready",   64'(obs_ready), 64'(0));
            if (c == 10) chk("full_ready", 64'(obs_ready), 64'(0));
        end
        chk("full_lvl", 64'(f_cnt), 64'(DEPTH));
        chk("full_wen", 64'(obs_wen), 64'(0));
        chk("full_ovf", 64'(obs_ovf), 64'(0));
        rd_once = 1;
        cycle();
        cycle(); chk("resume", 64'(obs_ready), 64'(4'b0001));

        do_reset(4'hF);
        rd_pct = 50;
        cycle();
        inj_drop = 1; cycle(); inj_drop = 0;
        cycle();
        cycle(); chk("ack_set", 64'(obs_ack), 64'(1));
        repeat (5) cycle();
        chk("ack_sticky", 64'(obs_ack), 64'(1));

        rd_pct = 100;
        inj_ovf = 1; cycle(); inj_ovf = 0;
        cycle();
        cycle(); chk("ovf_set", 64'(obs_ovf), 64'(1));
        grants = 0;
        repeat (6) begin
            cycle();
            if (obs_ready != '0) grants++;
        end
        chk("ovf_arb", 64'(grants > 0), 64'(1));
        chk("ovf_sticky", 64'(obs_ovf), 64'(1));

        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                valid_pct = int'($urandom_range(100));
                rd_pct    = int'($urandom_range(100));
                en_mask   = N'($urandom);
            end
            inj_drop = ($urandom_range(39) == 0);
            inj_ovf  = ($urandom_range(149) == 0);
            if ($urandom_range(299) == 0) begin
                rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end else begin
                cycle();
            end
        end
        inj_drop = 0; inj_ovf = 0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
